// File: rtl/segment_readback.sv
// Reconstructs a decimal value from a two-digit seven-segment display, either
// static or rotating three digits across the two positions.
module segment_readback #(
  parameter int STABLE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] seg1,
  input  logic [8:0] seg2,
  input  logic       shift_en,
  input  logic       shift_tick,
  output logic [9:0] value,
  output logic       value_valid,
  output logic [1:0] err_code,
  output logic       err_pulse
);

  localparam int CW = $clog2(STABLE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE);
  localparam logic [1:0] ERR_BADSEG   = 2'b01;
  localparam logic [1:0] ERR_MISMATCH = 2'b10;
  localparam logic [1:0] ERR_NOSAMPLE = 2'b11;

  typedef enum logic [1:0] {IDLE, ROT0, ROT1, ROT2} state_t;

  state_t        state_q, state_d;
  logic [8:0]    seg1_q, seg2_q;
  logic [17:0]   prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          change, acc_d, acc_q;
  logic [7:0]    accl_q, accr_q;
  logic          sen_q, sen_prev_q, sen_rise, sen_fall;
  logic          abort, tick_eval;

  logic [3:0]    d2_q, d1_q, d1b_q, d0_q, d0b_q, d2b_q;
  logic [3:0]    d2_d, d1_d, d1b_d, d0_d, d0b_d, d2b_d;
  logic [2:0]    fill_q, fill_d;
  logic [9:0]    value_q, value_d, rot_val, idle_val;
  logic          valid_q, valid_d, errp_q, errp_d;
  logic [1:0]    err_q, err_d;

  logic [5:0]    dec_l, dec_r;
  logic          pair_bad, pair_blank, pair_ok;

  // Result is {bad, blank, digit[3:0]}.
  function automatic logic [5:0] decode(input logic en, input logic [6:0] pat);
    logic [5:0] r;
    r = 6'b100000;
    if (!en) begin
      r = 6'b010000;
    end else begin
      case (pat)
        7'h3F:   r = {2'b00, 4'd0};
        7'h06:   r = {2'b00, 4'd1};
        7'h5B:   r = {2'b00, 4'd2};
        7'h4F:   r = {2'b00, 4'd3};
        7'h66:   r = {2'b00, 4'd4};
        7'h6D:   r = {2'b00, 4'd5};
        7'h7D:   r = {2'b00, 4'd6};
        7'h07:   r = {2'b00, 4'd7};
        7'h7F:   r = {2'b00, 4'd8};
        7'h6F:   r = {2'b00, 4'd9};
        default: r = 6'b100000;
      endcase
    end
    return r;
  endfunction

  assign change = ({seg1_q, seg2_q} != prev_q);

  always_comb begin
    cnt_d = cnt_q;
    if (change) begin
      cnt_d = CW'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // A pair is accepted exactly once, when its sample count first reaches STABLE.
  assign acc_d = (cnt_d == CNT_MAX) && (change || (cnt_q != CNT_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg1_q     <= '0;
      seg2_q     <= '0;
      prev_q     <= '0;
      cnt_q      <= '0;
      acc_q      <= 1'b0;
      accl_q     <= '0;
      accr_q     <= '0;
      sen_q      <= 1'b0;
      sen_prev_q <= 1'b0;
    end else begin
      seg1_q     <= seg1;
      seg2_q     <= seg2;
      prev_q     <= {seg1_q, seg2_q};
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      accl_q     <= {seg1_q[8], seg1_q[6:0]};
      accr_q     <= {seg2_q[8], seg2_q[6:0]};
      sen_q      <= shift_en;
      sen_prev_q <= sen_q;
    end
  end

  assign dec_l      = decode(accl_q[7], accl_q[6:0]);
  assign dec_r      = decode(accr_q[7], accr_q[6:0]);
  assign pair_bad   = dec_l[5] | dec_r[5];
  assign pair_blank = dec_l[4] | dec_r[4];
  assign pair_ok    = acc_q & ~pair_bad & ~pair_blank;
  assign idle_val   = ({6'd0, dec_l[3:0]} * 10'd10) + {6'd0, dec_r[3:0]};

  assign sen_rise  = sen_q & ~sen_prev_q;
  assign sen_fall  = ~sen_q & sen_prev_q;
  assign abort     = sen_rise | (sen_fall & (state_q != IDLE));
  assign tick_eval = shift_tick & (state_q == ROT2) & ~abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (sen_rise) begin
      state_d = ROT0;
    end else if (sen_fall) begin
      state_d = IDLE;
    end else if (shift_tick) begin
      case (state_q)
        IDLE:    state_d = IDLE;
        ROT0:    state_d = ROT1;
        ROT1:    state_d = ROT2;
        ROT2:    state_d = ROT0;
        default: state_d = IDLE;
      endcase
    end
  end

  // Same-cycle acceptance is folded into the slots before the revolution is judged.
  always_comb begin
    value_d = value_q;
    valid_d = 1'b0;
    err_d   = err_q;
    errp_d  = 1'b0;
    d2_d    = d2_q;
    d1_d    = d1_q;
    d1b_d   = d1b_q;
    d0_d    = d0_q;
    d0b_d   = d0b_q;
    d2b_d   = d2b_q;
    fill_d  = fill_q;
    rot_val = '0;
    if (abort) begin
      d2_d   = '0;
      d1_d   = '0;
      d1b_d  = '0;
      d0_d   = '0;
      d0b_d  = '0;
      d2b_d  = '0;
      fill_d = '0;
    end else begin
      if (pair_ok) begin
        case (state_q)
          IDLE: begin
            if (idle_val != value_q) begin
              value_d = idle_val;
              valid_d = 1'b1;
            end
          end
          ROT0: begin
            d2_d      = dec_l[3:0];
            d1_d      = dec_r[3:0];
            fill_d[0] = 1'b1;
          end
          ROT1: begin
            d1b_d     = dec_l[3:0];
            d0_d      = dec_r[3:0];
            fill_d[1] = 1'b1;
          end
          ROT2: begin
            d0b_d     = dec_l[3:0];
            d2b_d     = dec_r[3:0];
            fill_d[2] = 1'b1;
          end
          default: ;
        endcase
      end else if (acc_q && pair_bad && !tick_eval) begin
        err_d  = ERR_BADSEG;
        errp_d = 1'b1;
      end
      if (tick_eval) begin
        rot_val = ({6'd0, d2_d} * 10'd100) + ({6'd0, d1_d} * 10'd10) + {6'd0, d0_d};
        if (fill_d != 3'b111) begin
          err_d  = ERR_NOSAMPLE;
          errp_d = 1'b1;
        end else if ((d1_d != d1b_d) || (d0_d != d0b_d) || (d2_d != d2b_d)) begin
          err_d  = ERR_MISMATCH;
          errp_d = 1'b1;
        end else begin
          value_d = rot_val;
          valid_d = 1'b1;
        end
        d2_d   = '0;
        d1_d   = '0;
        d1b_d  = '0;
        d0_d   = '0;
        d0b_d  = '0;
        d2b_d  = '0;
        fill_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
      valid_q <= 1'b0;
      err_q   <= '0;
      errp_q  <= 1'b0;
      d2_q    <= '0;
      d1_q    <= '0;
      d1b_q   <= '0;
      d0_q    <= '0;
      d0b_q   <= '0;
      d2b_q   <= '0;
      fill_q  <= '0;
    end else begin
      value_q <= value_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      errp_q  <= errp_d;
      d2_q    <= d2_d;
      d1_q    <= d1_d;
      d1b_q   <= d1b_d;
      d0_q    <= d0_d;
      d0b_q   <= d0b_d;
      d2b_q   <= d2b_d;
      fill_q  <= fill_d;
    end
  end

  assign value       = value_q;
  assign value_valid = valid_q;
  assign err_code    = err_q;
  assign err_pulse   = errp_q;

endmodule

// File: tb/tb_segment_readback.sv
// Scoreboard bench for segment_readback: stimulus pushes expected strobes,
// a negedge monitor pops and compares every value_valid / err_pulse.
module tb_segment_readback;

  localparam int STABLE = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] seg1, seg2;
  logic       shift_en, shift_tick;
  logic [9:0] value;
  logic       value_valid;
  logic [1:0] err_code;
  logic       err_pulse;

  typedef struct {
    bit isErr;
    int expValue;
    int expErr;
    int expCyc;
  } exp_t;

  exp_t scoreQ[$];
  exp_t monE;
  int   testsRun    = 0;
  int   testsFailed = 0;
  int   cyc         = 0;

  segment_readback #(.STABLE(STABLE)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg1       (seg1),
    .seg2       (seg2),
    .shift_en   (shift_en),
    .shift_tick (shift_tick),
    .value      (value),
    .value_valid(value_valid),
    .err_code   (err_code),
    .err_pulse  (err_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic pushExpect(input bit isErr, input int v, input int e, input int c);
    exp_t x;
    x.isErr    = isErr;
    x.expValue = v;
    x.expErr   = e;
    x.expCyc   = c;
    scoreQ.push_back(x);
  endtask

  // Called at a negedge; drives the pair and holds it for n cycles.
  task automatic applyStimulus(input logic [8:0] s1, input logic [8:0] s2, input int n);
    seg1 = s1;
    seg2 = s2;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulseTick();
    shift_tick = 1'b1;
    @(negedge clk);
    shift_tick = 1'b0;
  endtask

  task automatic runFrames(input logic [8:0] a1, input logic [8:0] a2,
                           input logic [8:0] b1, input logic [8:0] b2,
                           input logic [8:0] c1, input logic [8:0] c2);
    applyStimulus(a1, a2, 20);
    pulseTick();
    applyStimulus(b1, b2, 20);
    pulseTick();
    applyStimulus(c1, c2, 20);
  endtask

  task automatic expectDrained(input string name);
    for (int i = 0; i < 40 && scoreQ.size() != 0; i++) @(negedge clk);
    checkOutput({name, "_drained"}, scoreQ.size(), 0);
    scoreQ.delete();
  endtask

  always @(negedge clk) begin
    if (!rst && (value_valid || err_pulse)) begin
      if (scoreQ.size() == 0) begin
        checkOutput("unexpected_strobe", int'({value_valid, err_pulse}), 0);
      end else begin
        monE = scoreQ.pop_front();
        checkOutput("strobe_kind", int'({value_valid, err_pulse}), monE.isErr ? 1 : 2);
        checkOutput("strobe_value", int'(value), monE.expValue);
        checkOutput("strobe_err_code", int'(err_code), monE.expErr);
        if (monE.expCyc >= 0) checkOutput("strobe_latency", cyc, monE.expCyc);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    seg1       = '0;
    seg2       = '0;
    shift_en   = 1'b0;
    shift_tick = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_value", int'(value), 0);
    checkOutput("reset_valid", int'(value_valid), 0);
    checkOutput("reset_err_code", int'(err_code), 0);
    checkOutput("reset_err_pulse", int'(err_pulse), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Static 42, then held with no repeat strobe.
    pushExpect(0, 42, 0, cyc + STABLE + 2);
    applyStimulus(9'h166, 9'h15B, 30);
    applyStimulus(9'h166, 9'h15B, 30);
    expectDrained("static");
    checkOutput("static_value", int'(value), 42);

    // Rotation 3-5-7 gives 357.
    shift_en = 1'b1;
    runFrames(9'h14F, 9'h16D, 9'h16D, 9'h107, 9'h107, 9'h14F);
    pushExpect(0, 357, 0, cyc + 1);
    pulseTick();
    repeat (5) @(negedge clk);
    shift_en = 1'b0;
    repeat (10) @(negedge clk);
    expectDrained("rotation");

    // Middle frame disagrees on d1.
    shift_en = 1'b1;
    runFrames(9'h14F, 9'h16D, 9'h166, 9'h107, 9'h107, 9'h14F);
    pushExpect(1, 357, 2, cyc + 1);
    pulseTick();
    repeat (5) @(negedge clk);
    shift_en = 1'b0;
    repeat (10) @(negedge clk);
    expectDrained("mismatch");
    checkOutput("mismatch_value_kept", int'(value), 357);

    // Glitching pairs are never accepted; a stable bad segment is.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(9'h106, 9'h15B, 2);
      applyStimulus(9'h14F, 9'h166, 2);
    end
    checkOutput("glitch_err_code", int'(err_code), 2);
    pushExpect(1, 357, 1, -1);
    applyStimulus(9'h101, 9'h13F, 20);
    expectDrained("badseg");

    // No stable frame during ROT1 -> NOSAMPLE at revolution end.
    shift_en = 1'b1;
    applyStimulus(9'h14F, 9'h16D, 20);
    pulseTick();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(9'h106, 9'h15B, 2);
      applyStimulus(9'h14F, 9'h166, 2);
    end
    pulseTick();
    applyStimulus(9'h107, 9'h14F, 20);
    pushExpect(1, 357, 3, cyc + 1);
    pulseTick();
    expectDrained("nosample");

    // Second revolution abandoned in ROT2: silent return to IDLE.
    applyStimulus(9'h14F, 9'h16D, 20);
    pulseTick();
    applyStimulus(9'h16D, 9'h107, 20);
    pulseTick();
    applyStimulus(9'h107, 9'h14F, 10);
    shift_en = 1'b0;
    repeat (20) @(negedge clk);
    expectDrained("drop_in_rot2");
    checkOutput("drop_err_code", int'(err_code), 3);

    // Reset during ROT1.
    shift_en = 1'b1;
    applyStimulus(9'h16D, 9'h107, 20);
    pulseTick();
    applyStimulus(9'h107, 9'h14F, 10);
    rst      = 1'b1;
    shift_en = 1'b0;
    seg1     = '0;
    seg2     = '0;
    #1;
    checkOutput("midreset_value", int'(value), 0);
    checkOutput("midreset_valid", int'(value_valid), 0);
    checkOutput("midreset_err_code", int'(err_code), 0);
    checkOutput("midreset_err_pulse", int'(err_pulse), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("post_reset_value", int'(value), 0);
    pushExpect(0, 89, 0, cyc + STABLE + 2);
    applyStimulus(9'h17F, 9'h16F, 20);
    expectDrained("post_reset");

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
